// File: rtl/instr_loader.sv
// Byte-serial instruction memory loader: assembles little-endian byte quads into
// instructions, writes them to consecutive word addresses and tracks an XOR checksum.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  word_count_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  imem_write_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [`INSTR_LEN-1:0] imem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  words_written_o,
  output logic [`INSTR_LEN-1:0] checksum_o
);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_WIDTH-1:0]    remaining_q;
  logic [1:0]              idx_q;
  logic [23:0]             asm_q;
  logic                    imem_write_q;
  logic [ADDR_WIDTH-1:0]   imem_addr_q;
  logic [`INSTR_LEN-1:0]   imem_data_q;
  logic                    done_q;
  logic [CNT_WIDTH-1:0]    words_q;
  logic [`INSTR_LEN-1:0]   checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      imem_write_q <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      done_q       <= 1'b0;
      words_q      <= '0;
      checksum_q   <= '0;
    end else begin
      done_q       <= 1'b0;
      imem_write_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            addr_q      <= base_addr_i;
            remaining_q <= word_count_i;
            words_q     <= '0;
            checksum_q  <= '0;
            idx_q       <= '0;
            if (word_count_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRecv;
            end
          end
        end
        StRecv: begin
          if (byte_valid_i) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              // Output registers are loaded here so the write strobe cycle sees them stable.
              imem_data_q  <= {byte_data_i, asm_q};
              imem_addr_q  <= addr_q;
              imem_write_q <= 1'b1;
              state_q      <= StWrite;
            end else begin
              asm_q[{idx_q, 3'b000} +: 8] <= byte_data_i;
            end
          end
        end
        StWrite: begin
          checksum_q  <= checksum_q ^ imem_data_q;
          words_q     <= words_q + CNT_WIDTH'(1);
          remaining_q <= remaining_q - CNT_WIDTH'(1);
          addr_q      <= addr_q + ADDR_WIDTH'(1);
          idx_q       <= '0;
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StRecv;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign byte_ready_o    = (state_q == StRecv);
  assign busy_o          = (state_q != StIdle);
  assign imem_write_o    = imem_write_q;
  assign imem_addr_o     = imem_addr_q;
  assign imem_data_o     = imem_data_q;
  assign done_o          = done_q;
  assign words_written_o = words_q;
  assign checksum_o      = checksum_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: single word, backpressure, wrap, zero count,
// ignored restart and asynchronous reset mid-load.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        imem_write;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        busy;
  logic        done;
  logic [8:0]  words_written;
  logic [31:0] checksum;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          ready_seen = 0;

  instr_loader #(.ADDR_WIDTH(8), .CNT_WIDTH(9)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .base_addr_i     (base_addr),
    .word_count_i    (word_count),
    .byte_valid_i    (byte_valid),
    .byte_data_i     (byte_data),
    .byte_ready_o    (byte_ready),
    .imem_write_o    (imem_write),
    .imem_addr_o     (imem_addr),
    .imem_data_o     (imem_data),
    .busy_o          (busy),
    .done_o          (done),
    .words_written_o (words_written),
    .checksum_o      (checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_write) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_data);
    end
    if (byte_ready) ready_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base, input logic [8:0] cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    idle_cycle();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    byte_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gap) idle_cycle();
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    idle_cycle();
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_write", 32'(imem_write), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_data", imem_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_csum", checksum, 32'd0);
    repeat (2) idle_cycle();
    rst_n = 1'b1;
    idle_cycle();

    // Single word with exact latency checks
    do_start(8'h10, 9'd1);
    @(negedge clk);
    check("sw_busy", 32'(busy), 32'd1);
    check("sw_ready", 32'(byte_ready), 32'd1);
    idle_cycle();
    send_byte(8'h23);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h8B);
    @(negedge clk);
    check("sw_write", 32'(imem_write), 32'd1);
    check("sw_addr", 32'(imem_addr), 32'h10);
    check("sw_data", imem_data, 32'h8B020023);
    check("sw_ready_in_write", 32'(byte_ready), 32'd0);
    @(negedge clk);
    check("sw_done", 32'(done), 32'd1);
    check("sw_busy_done", 32'(busy), 32'd1);
    check("sw_write_off", 32'(imem_write), 32'd0);
    check("sw_words", 32'(words_written), 32'd1);
    check("sw_csum", checksum, 32'h8B020023);
    @(negedge clk);
    check("sw_done_pulse", 32'(done), 32'd0);
    check("sw_busy_off", 32'(busy), 32'd0);
    check("sw_nwrites", wr_addr.size(), 32'd1);
    check("sw_hold_words", 32'(words_written), 32'd1);
    idle_cycle();

    // Backpressure: gaps between bytes, valid held across WRITE
    wr_addr.delete();
    wr_data.delete();
    do_start(8'h00, 9'd3);
    send_word(32'h8B020023, 1'b1);
    send_word(32'hF8400041, 1'b1);
    send_word(32'hB4000060, 1'b0);
    wait_idle();
    check("bp_nwrites", wr_addr.size(), 32'd3);
    check("bp_addr0", 32'(wr_addr[0]), 32'h00);
    check("bp_addr1", 32'(wr_addr[1]), 32'h01);
    check("bp_addr2", 32'(wr_addr[2]), 32'h02);
    check("bp_data0", wr_data[0], 32'h8B020023);
    check("bp_data1", wr_data[1], 32'hF8400041);
    check("bp_data2", wr_data[2], 32'hB4000060);
    check("bp_words", 32'(words_written), 32'd3);
    check("bp_csum", checksum, 32'hC7420002);

    // Address wrap
    wr_addr.delete();
    wr_data.delete();
    do_start(8'hFF, 9'd2);
    send_word(32'h11223344, 1'b0);
    send_word(32'hA5A5A5A5, 1'b0);
    wait_idle();
    check("wr_nwrites", wr_addr.size(), 32'd2);
    check("wr_addr0", 32'(wr_addr[0]), 32'hFF);
    check("wr_addr1", 32'(wr_addr[1]), 32'h00);
    check("wr_csum", checksum, 32'hB48796E1);

    // Zero count
    wr_addr.delete();
    ready_seen = 0;
    do_start(8'h20, 9'd0);
    @(negedge clk);
    check("zc_done", 32'(done), 32'd1);
    check("zc_busy", 32'(busy), 32'd1);
    check("zc_words", 32'(words_written), 32'd0);
    check("zc_csum", checksum, 32'd0);
    @(negedge clk);
    check("zc_done_pulse", 32'(done), 32'd0);
    check("zc_busy_off", 32'(busy), 32'd0);
    repeat (3) idle_cycle();
    check("zc_nwrites", wr_addr.size(), 32'd0);
    check("zc_ready_seen", ready_seen, 32'd0);

    // Start while busy is ignored
    wr_addr.delete();
    wr_data.delete();
    do_start(8'h40, 9'd2);
    send_byte(8'h01);
    do_start(8'h80, 9'd5);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(32'hDEADBEEF, 1'b0);
    wait_idle();
    check("sb_nwrites", wr_addr.size(), 32'd2);
    check("sb_addr0", 32'(wr_addr[0]), 32'h40);
    check("sb_addr1", 32'(wr_addr[1]), 32'h41);
    check("sb_data0", wr_data[0], 32'h04030201);
    check("sb_words", 32'(words_written), 32'd2);

    // Asynchronous reset mid-RECV
    wr_addr.delete();
    do_start(8'h30, 9'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ready", 32'(byte_ready), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_write", 32'(imem_write), 32'd0);
    check("ar_addr", 32'(imem_addr), 32'd0);
    check("ar_data", imem_data, 32'd0);
    check("ar_words", 32'(words_written), 32'd0);
    check("ar_csum", checksum, 32'd0);
    check("ar_done", 32'(done), 32'd0);
    idle_cycle();
    rst_n = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hCC;
    repeat (8) idle_cycle();
    byte_valid = 1'b0;
    check("ar_nwrites", wr_addr.size(), 32'd0);
    check("ar_busy_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
